// File: rtl/trap_redirect_controller_pkg.sv
// Shared constants and encodings for the trap/mret redirect controller.
// Optional feature macro used by this block: TRAP_COUNTER_EN.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

package trap_redirect_controller_pkg;

  localparam logic [3:0] NO_EXC = 4'hF;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_e;

  typedef enum logic {
    SLOT_F = 1'b0,
    SLOT_M = 1'b1
  } slot_e;

  // Bit positions inside the arbiter's winner one-hot.
  localparam int WIN_F    = 0;
  localparam int WIN_MRET = 1;
  localparam int WIN_M    = 2;

  function automatic int xlen_width(input int xlen);
    return 1 << (xlen + 4);
  endfunction

endpackage

// File: rtl/trap_redirect_controller_if.sv
// Redirect handshake between the trap controller (master) and fetch (slave).
interface trap_redirect_controller_if #(
  parameter int W = 64
) ();

  logic         o_redirect_valid;
  logic [W-1:0] o_redirect_pc;
  logic         i_redirect_ready;

  modport master (
    output o_redirect_valid,
    output o_redirect_pc,
    input  i_redirect_ready
  );

  modport slave (
    input  o_redirect_valid,
    input  o_redirect_pc,
    output i_redirect_ready
  );

endinterface

// File: rtl/trap_redirect_controller_arbiter.sv
// Age-ordered priority select of E/M exception, mret and fetch exception.
// The oldest instruction wins; the losers are squashed by the later flush.
module trap_arbiter
  import trap_redirect_controller_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         exc_valid_f_i,
  input  logic [3:0]   exc_code_f_i,
  input  logic [W-1:0] exc_pc_f_i,
  input  logic         exc_valid_m_i,
  input  logic [3:0]   exc_code_m_i,
  input  logic [W-1:0] exc_pc_m_i,
  input  logic [W-1:0] exc_addr_m_i,
  input  logic         mret_i,
  output logic [2:0]   win_o,
  output logic [3:0]   code_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] addr_o
);

  always_comb begin
    // NOTE: every output gets a default before the priority chain, so no path leaves a value unassigned and no latch is inferred.
    win_o  = '0;
    code_o = NO_EXC;
    pc_o   = '0;
    addr_o = '0;
    if (exc_valid_m_i) begin
      win_o[WIN_M] = 1'b1;
      code_o       = exc_code_m_i;
      pc_o         = exc_pc_m_i;
      addr_o       = exc_addr_m_i;
    end else if (mret_i) begin
      win_o[WIN_MRET] = 1'b1;
    end else if (exc_valid_f_i) begin
      win_o[WIN_F] = 1'b1;
      code_o       = exc_code_f_i;
      pc_o         = exc_pc_f_i;
    end
  end

endmodule

// File: rtl/trap_redirect_controller.sv
// Trap/mret controller: arbitrates, commits one CSR strobe, flushes, redirects fetch.
// Optional trap counter enabled by defining TRAP_COUNTER_EN.
module trap_redirect_controller
  import trap_redirect_controller_pkg::*;
#(
  parameter  int XLEN = `XLEN_64b,
  localparam int W    = xlen_width(XLEN)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic         i_exc_valid_f,
  input  logic [3:0]   i_exc_code_f,
  input  logic [W-1:0] i_exc_pc_f,
  input  logic         i_exc_valid_m,
  input  logic [3:0]   i_exc_code_m,
  input  logic [W-1:0] i_exc_pc_m,
  input  logic [W-1:0] i_exc_addr_m,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_mepc,
  input  logic [W-1:0] i_mtvec,
  trap_redirect_controller_if.master redir,
  output logic [3:0]   o_exception_code_f_d_ff,
  output logic [W-1:0] o_exception_pc_f_d_ff,
  output logic [3:0]   o_exception_code_e_m_ff,
  output logic [W-1:0] o_exception_pc_e_m_ff,
  output logic [W-1:0] o_exception_addr_e_m_ff,
  output logic         o_mret_e,
  output logic         o_flush,
  output logic         o_stall_f
`ifdef TRAP_COUNTER_EN
  ,
  output logic [63:0]  o_trap_count
`endif
);

  state_e       state_q, state_d;
  kind_e        kind_q, kind_d;
  slot_e        slot_q, slot_d;
  logic [3:0]   f_code_q, f_code_d;
  logic [W-1:0] f_pc_q, f_pc_d;
  logic [3:0]   m_code_q, m_code_d;
  logic [W-1:0] m_pc_q, m_pc_d;
  logic [W-1:0] m_addr_q, m_addr_d;

  logic [2:0]   win;
  logic [3:0]   sel_code;
  logic [W-1:0] sel_pc;
  logic [W-1:0] sel_addr;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         unused_mtvec_lsb;

  assign unused_mtvec_lsb = ^i_mtvec[1:0];

  trap_arbiter #(.W(W)) u_arbiter (
    .exc_valid_f_i (i_exc_valid_f),
    .exc_code_f_i  (i_exc_code_f),
    .exc_pc_f_i    (i_exc_pc_f),
    .exc_valid_m_i (i_exc_valid_m),
    .exc_code_m_i  (i_exc_code_m),
    .exc_pc_m_i    (i_exc_pc_m),
    .exc_addr_m_i  (i_exc_addr_m),
    .mret_i        (i_mret_e),
    .win_o         (win),
    .code_o        (sel_code),
    .pc_o          (sel_pc),
    .addr_o        (sel_addr)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    if (i_rst) begin
      state_q <= IDLE;
      kind_q  <= KIND_TRAP;
      slot_q  <= SLOT_F;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      slot_q  <= slot_d;
    end
  end

  // NOTE: the payload registers carry no reset; they are only observed in COMMIT, which always follows a load.
  always_ff @(posedge i_clk) begin
    f_code_q <= f_code_d;
    f_pc_q   <= f_pc_d;
    m_code_q <= m_code_d;
    m_pc_q   <= m_pc_d;
    m_addr_q <= m_addr_d;
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    slot_d   = slot_q;
    f_code_d = f_code_q;
    f_pc_d   = f_pc_q;
    m_code_d = m_code_q;
    m_pc_d   = m_pc_q;
    m_addr_d = m_addr_q;
    if (i_clk_en) begin
      case (state_q)
        IDLE: begin
          if (|win) begin
            state_d = COMMIT;
            kind_d  = win[WIN_MRET] ? KIND_MRET : KIND_TRAP;
            slot_d  = win[WIN_M] ? SLOT_M : SLOT_F;
            if (win[WIN_M]) begin
              m_code_d = sel_code;
              m_pc_d   = sel_pc;
              m_addr_d = sel_addr;
            end
            if (win[WIN_F]) begin
              f_code_d = sel_code;
              f_pc_d   = sel_pc;
            end
          end
        end
        COMMIT:   state_d = REDIRECT;
        REDIRECT: if (redir.i_redirect_ready) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Outputs decode from registered state, so a frozen clock enable freezes them too.
  always_comb begin
    o_exception_code_f_d_ff = NO_EXC;
    o_exception_pc_f_d_ff   = '0;
    o_exception_code_e_m_ff = NO_EXC;
    o_exception_pc_e_m_ff   = '0;
    o_exception_addr_e_m_ff = '0;
    o_mret_e                = 1'b0;
    o_flush                 = 1'b0;
    o_stall_f               = 1'b0;
    redirect_valid          = 1'b0;
    redirect_pc             = '0;
    case (state_q)
      COMMIT: begin
        o_flush   = 1'b1;
        o_stall_f = 1'b1;
        if (kind_q == KIND_MRET) begin
          o_mret_e = 1'b1;
        end else if (slot_q == SLOT_M) begin
          o_exception_code_e_m_ff = m_code_q;
          o_exception_pc_e_m_ff   = m_pc_q;
          o_exception_addr_e_m_ff = m_addr_q;
        end else begin
          o_exception_code_f_d_ff = f_code_q;
          o_exception_pc_f_d_ff   = f_pc_q;
        end
      end
      REDIRECT: begin
        o_flush        = 1'b1;
        o_stall_f      = 1'b1;
        redirect_valid = 1'b1;
        // mtvec/mepc are read live so the value committed in COMMIT is already visible.
        redirect_pc    = (kind_q == KIND_TRAP) ? {i_mtvec[W-1:2], 2'b00} : i_mepc;
      end
      default: ;
    endcase
  end

  assign redir.o_redirect_valid = redirect_valid;
  assign redir.o_redirect_pc    = redirect_pc;

`ifdef TRAP_COUNTER_EN
  logic [63:0] trap_count_q, trap_count_d;

  always_comb begin
    trap_count_d = trap_count_q;
    if (i_clk_en && state_q == COMMIT && kind_q == KIND_TRAP && !(&trap_count_q))
      trap_count_d = trap_count_q + 64'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) trap_count_q <= '0;
    else       trap_count_q <= trap_count_d;
  end

  assign o_trap_count = trap_count_q;
`endif

endmodule

// File: tb/tb_trap_redirect_controller.sv
// Randomized scoreboard bench for trap_redirect_controller with directed corner cases.
module tb_trap_redirect_controller;
  import trap_redirect_controller_pkg::*;

  localparam int W = 1 << (`XLEN_64b + 4);

  logic         i_clk = 1'b0;
  logic         i_rst, i_clk_en;
  logic         i_exc_valid_f, i_exc_valid_m, i_mret_e;
  logic [3:0]   i_exc_code_f, i_exc_code_m;
  logic [W-1:0] i_exc_pc_f, i_exc_pc_m, i_exc_addr_m, i_mepc, i_mtvec;
  logic [3:0]   o_code_f, o_code_m;
  logic [W-1:0] o_pc_f, o_pc_m, o_addr_m;
  logic         o_mret_e, o_flush, o_stall_f;
`ifdef TRAP_COUNTER_EN
  logic [63:0]  o_trap_count;
`endif

  trap_redirect_controller_if #(.W(W)) redir ();

  trap_redirect_controller #(.XLEN(`XLEN_64b)) dut (
    .i_clk                   (i_clk),
    .i_rst                   (i_rst),
    .i_clk_en                (i_clk_en),
    .i_exc_valid_f           (i_exc_valid_f),
    .i_exc_code_f            (i_exc_code_f),
    .i_exc_pc_f              (i_exc_pc_f),
    .i_exc_valid_m           (i_exc_valid_m),
    .i_exc_code_m            (i_exc_code_m),
    .i_exc_pc_m              (i_exc_pc_m),
    .i_exc_addr_m            (i_exc_addr_m),
    .i_mret_e                (i_mret_e),
    .i_mepc                  (i_mepc),
    .i_mtvec                 (i_mtvec),
    .redir                   (redir),
    .o_exception_code_f_d_ff (o_code_f),
    .o_exception_pc_f_d_ff   (o_pc_f),
    .o_exception_code_e_m_ff (o_code_m),
    .o_exception_pc_e_m_ff   (o_pc_m),
    .o_exception_addr_e_m_ff (o_addr_m),
    .o_mret_e                (o_mret_e),
    .o_flush                 (o_flush),
    .o_stall_f               (o_stall_f)
`ifdef TRAP_COUNTER_EN
    ,
    .o_trap_count            (o_trap_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    kind_e        kind;
    slot_e        slot;
    logic [3:0]   code;
    logic [W-1:0] pc;
    logic [W-1:0] addr;
  } commit_t;

  commit_t      commit_q[$];
  logic [W-1:0] redir_q[$];
  int           phase;       // 0 idle, 1 committing, 2 waiting for fetch
  kind_e        cur_kind;
  logic [63:0]  model_count;
  int           checks, failures;
  bit           mon_en;
  logic [3:0]   causes [5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the arbitration and sequencing rules to the inputs seen at an edge.
  task automatic model_edge();
    commit_t c;
    if (i_rst) begin
      phase = 0;
      commit_q.delete();
      redir_q.delete();
      model_count = '0;
    end else if (i_clk_en) begin
      case (phase)
        0: if (i_exc_valid_m || i_mret_e || i_exc_valid_f) begin
          c.addr = '0;
          if (i_exc_valid_m) begin
            c.kind = KIND_TRAP; c.slot = SLOT_M;
            c.code = i_exc_code_m; c.pc = i_exc_pc_m; c.addr = i_exc_addr_m;
          end else if (i_mret_e) begin
            c.kind = KIND_MRET; c.slot = SLOT_F; c.code = NO_EXC; c.pc = '0;
          end else begin
            c.kind = KIND_TRAP; c.slot = SLOT_F;
            c.code = i_exc_code_f; c.pc = i_exc_pc_f;
          end
          commit_q.push_back(c);
          redir_q.push_back(c.kind == KIND_TRAP ? i_mtvec - (i_mtvec % 4) : i_mepc);
          cur_kind = c.kind;
          phase = 1;
        end
        1: begin
          phase = 2;
          if (cur_kind == KIND_TRAP && model_count != {64{1'b1}}) model_count++;
        end
        default: if (redir.i_redirect_ready) phase = 0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic clear_req();
    i_exc_valid_f = 1'b0;
    i_exc_valid_m = 1'b0;
    i_mret_e      = 1'b0;
  endtask

  task automatic do_req(input bit vm, input bit vf, input bit mr, input logic [3:0] code);
    i_exc_valid_m = vm; i_exc_code_m = code; i_exc_pc_m = 64'h100 + code; i_exc_addr_m = 64'h200;
    i_exc_valid_f = vf; i_exc_code_f = code; i_exc_pc_f = 64'h300;
    i_mret_e      = mr;
    step();
    clear_req();
    step();
    step();
  endtask

  // Monitor: compares presented outputs against the scoreboard queues.
  always @(negedge i_clk) begin : monitor
    logic    present;
    logic    prev_present;
    commit_t c;
    if (mon_en) begin
      present = (o_code_f != NO_EXC) || (o_code_m != NO_EXC) || o_mret_e;
      check("commit_window", present, phase == 1);
      check("flush", o_flush, phase != 0);
      check("stall_f", o_stall_f, phase != 0);
      check("redirect_valid", redir.o_redirect_valid, phase == 2);
      if (present && !prev_present) begin
        if (commit_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_commit actual=present required=none t=%0t", $time);
        end else begin
          c = commit_q.pop_front();
          check("mret_strobe", o_mret_e, c.kind == KIND_MRET);
          check("code_m", o_code_m, (c.kind == KIND_TRAP && c.slot == SLOT_M) ? c.code : NO_EXC);
          check("code_f", o_code_f, (c.kind == KIND_TRAP && c.slot == SLOT_F) ? c.code : NO_EXC);
          check("pc_m", o_pc_m, (c.kind == KIND_TRAP && c.slot == SLOT_M) ? c.pc : '0);
          check("addr_m", o_addr_m, (c.kind == KIND_TRAP && c.slot == SLOT_M) ? c.addr : '0);
          check("pc_f", o_pc_f, (c.kind == KIND_TRAP && c.slot == SLOT_F) ? c.pc : '0);
        end
      end
      if (!present) check("idle_pc_zero", o_pc_f | o_pc_m | o_addr_m, '0);
      if (redir.o_redirect_valid) begin
        if (redir_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_redirect actual=%h required=none t=%0t", redir.o_redirect_pc, $time);
        end else begin
          check("redirect_pc", redir.o_redirect_pc, redir_q[0]);
          if (redir.i_redirect_ready && i_clk_en && !i_rst) void'(redir_q.pop_front());
        end
      end else begin
        check("redirect_pc_idle", redir.o_redirect_pc, '0);
      end
`ifdef TRAP_COUNTER_EN
      check("trap_count", o_trap_count, model_count);
`endif
      prev_present = present;
    end else begin
      prev_present = 1'b0;
    end
  end

  initial begin
    causes[0] = CAUSE_INSTR_MISALIGNED; causes[1] = CAUSE_ILLEGAL;
    causes[2] = CAUSE_LOAD_MISALIGNED;  causes[3] = CAUSE_STORE_MISALIGNED;
    causes[4] = CAUSE_ECALL_M;
    checks = 0; failures = 0; mon_en = 1'b0; phase = 0; model_count = '0; cur_kind = KIND_TRAP;
    i_rst = 1'b1; i_clk_en = 1'b1; redir.i_redirect_ready = 1'b1;
    i_mepc = '0; i_mtvec = '0;
    // Reset with every request line active.
    i_exc_valid_m = 1'b1; i_exc_code_m = 4'd4; i_exc_pc_m = 64'h11; i_exc_addr_m = 64'h22;
    i_exc_valid_f = 1'b1; i_exc_code_f = 4'd2; i_exc_pc_f = 64'h33; i_mret_e = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    check("reset_code_f", o_code_f, NO_EXC);
    check("reset_code_m", o_code_m, NO_EXC);
    check("reset_flush", o_flush, 1'b0);
    i_rst = 1'b0;
    clear_req();
    step();

    // E/M exception with misaligned mtvec.
    i_mtvec = 64'h8001;
    i_exc_valid_m = 1'b1; i_exc_code_m = 4'd4; i_exc_pc_m = 64'h1000; i_exc_addr_m = 64'h2003;
    step();
    clear_req();
    check("m_exc_code", o_code_m, 4'd4);
    check("m_exc_pc", o_pc_m, 64'h1000);
    check("m_exc_addr", o_addr_m, 64'h2003);
    check("m_exc_flush", o_flush, 1'b1);
    step();
    check("m_redirect_valid", redir.o_redirect_valid, 1'b1);
    check("m_redirect_pc", redir.o_redirect_pc, 64'h8000);
    step();
    check("m_back_idle", o_flush, 1'b0);

    // All three requests together: only the E/M slot commits.
    i_exc_valid_m = 1'b1; i_exc_code_m = 4'd6; i_mret_e = 1'b1;
    i_exc_valid_f = 1'b1; i_exc_code_f = 4'd0;
    step();
    clear_req();
    check("simul_code_m", o_code_m, 4'd6);
    check("simul_mret", o_mret_e, 1'b0);
    check("simul_code_f", o_code_f, NO_EXC);
    step();
    step();

    // mret beats a younger fetch exception.
    i_mepc = 64'h4444;
    i_mret_e = 1'b1; i_exc_valid_f = 1'b1; i_exc_code_f = 4'd2;
    step();
    clear_req();
    check("mret_pulse", o_mret_e, 1'b1);
    check("mret_code_f", o_code_f, NO_EXC);
    step();
    check("mret_pulse_gone", o_mret_e, 1'b0);
    check("mret_redirect_pc", redir.o_redirect_pc, 64'h4444);
    step();

    // Backpressure, then a frozen clock enable with ready high.
    redir.i_redirect_ready = 1'b0;
    i_exc_valid_f = 1'b1; i_exc_code_f = 4'd11; i_exc_pc_f = 64'hABC0;
    step();
    step();
    i_exc_valid_m = 1'b1; i_exc_code_m = 4'd2; i_mret_e = 1'b1;
    repeat (5) step();
    check("bp_valid_held", redir.o_redirect_valid, 1'b1);
    i_clk_en = 1'b0; redir.i_redirect_ready = 1'b1;
    repeat (3) step();
    check("en_low_hold", redir.o_redirect_valid, 1'b1);
    clear_req();
    i_clk_en = 1'b1;
    step();
    check("en_high_handshake", redir.o_redirect_valid, 1'b0);

    // Counter: three traps and one mret, then reset while waiting on fetch.
    i_rst = 1'b1; step(); i_rst = 1'b0;
    do_req(1'b1, 1'b0, 1'b0, 4'd4);
    do_req(1'b0, 1'b1, 1'b0, 4'd0);
    do_req(1'b0, 1'b0, 1'b1, 4'd0);
    do_req(1'b1, 1'b1, 1'b0, 4'd11);
`ifdef TRAP_COUNTER_EN
    check("trap_count_three", o_trap_count, 64'd3);
`endif
    redir.i_redirect_ready = 1'b0;
    i_exc_valid_m = 1'b1; i_exc_code_m = 4'd6;
    step();
    clear_req();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("midreset_valid", redir.o_redirect_valid, 1'b0);
`ifdef TRAP_COUNTER_EN
    check("midreset_count", o_trap_count, 64'd0);
`endif
    redir.i_redirect_ready = 1'b1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge i_clk);
      model_edge();
      #1;
      i_rst                  = ($urandom_range(0, 299) == 0);
      i_clk_en               = ($urandom_range(0, 7) != 0);
      redir.i_redirect_ready = ($urandom_range(0, 2) != 0);
      i_exc_valid_m          = ($urandom_range(0, 3) == 0);
      i_mret_e               = ($urandom_range(0, 3) == 0);
      i_exc_valid_f          = ($urandom_range(0, 2) == 0);
      i_exc_code_m           = causes[$urandom_range(0, 4)];
      i_exc_code_f           = causes[$urandom_range(0, 4)];
      i_exc_pc_m             = {$urandom, $urandom};
      i_exc_pc_f             = {$urandom, $urandom};
      i_exc_addr_m           = {$urandom, $urandom};
      if (phase == 0) begin
        i_mtvec = {$urandom, $urandom};
        i_mepc  = {$urandom, $urandom};
      end
    end

    i_rst = 1'b0; i_clk_en = 1'b1; redir.i_redirect_ready = 1'b1;
    clear_req();
    repeat (6) step();
    check("commit_q_drained", commit_q.size(), 0);
    check("redir_q_drained", redir_q.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_redirect_controller.md
Name: trap_redirect_controller

Overview:
- Producer side of the CSR unit's exception/mret interface.
- Samples raw exception reports from fetch (F) and execute/memory (M), plus mret from E.
- Arbitrates by age and drives the registered exception code/pc/addr strobes that the CSR register file commits (mcause/mepc/mtval).
- Flushes pipeline registers, then hands a redirect PC (mtvec base or mepc) to fetch over a valid/ready handshake.

Parameters:
- XLEN, `XLEN_64b, width selector; data width W = 1<<(XLEN+4).
- NO_EXC, 4'hF, code driven on *_ff code outputs when no exception is being committed.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_clk_en  in  1  global clock enable; low freezes all state and outputs
- i_exc_valid_f  in  1  fetch-side exception present
- i_exc_code_f  in  4  fetch exception cause
- i_exc_pc_f  in  W  faulting fetch PC
- i_exc_valid_m  in  1  E/M-side exception present
- i_exc_code_m  in  4  E/M exception cause
- i_exc_pc_m  in  W  faulting instruction PC
- i_exc_addr_m  in  W  faulting data address (mtval)
- i_mret_e  in  1  mret in execute
- i_mepc  in  W  current mepc from CSR unit
- i_mtvec  in  W  current mtvec from CSR unit
- i_redirect_ready  in  1  fetch accepts redirect
- o_exception_code_f_d_ff  out  4  F exception commit code, else NO_EXC
- o_exception_pc_f_d_ff  out  W  F commit PC
- o_exception_code_e_m_ff  out  4  M exception commit code, else NO_EXC
- o_exception_pc_e_m_ff  out  W  M commit PC
- o_exception_addr_e_m_ff  out  W  M commit address
- o_mret_e  out  1  one-cycle mret commit strobe to CSR unit
- o_flush  out  1  flush F/D, D/E, E/M pipeline registers
- o_stall_f  out  1  hold fetch PC
- o_redirect_valid  out  1  redirect PC valid
- o_redirect_pc  out  W  target PC

Behaviour:
- Reset values:
  - State IDLE.
  - Code outputs = NO_EXC.
  - PC/addr outputs = 0.
  - o_mret_e, o_flush, o_stall_f, o_redirect_valid = 0.
  - o_redirect_pc = 0.
- FSM states: IDLE, COMMIT, REDIRECT. All transitions gated by i_clk_en.
- IDLE, arbitration priority (oldest instruction first):
  - i_exc_valid_m is highest. Latch code/pc/addr into the E/M slot, kind=TRAP, go to COMMIT.
  - Else i_mret_e. Kind=MRET, go to COMMIT. Any simultaneous F exception is discarded because it is younger.
  - Else i_exc_valid_f. Latch into the F/D slot, kind=TRAP, go to COMMIT.
  - Losing requests are dropped; the flush squashes them.
- COMMIT, exactly 1 cycle:
  - Drive the latched slot onto its *_ff outputs. The other slot's code stays NO_EXC.
  - For kind=MRET, pulse o_mret_e instead.
  - o_flush=1, o_stall_f=1. Go to REDIRECT.
- REDIRECT:
  - o_flush=1, o_stall_f=1, o_redirect_valid=1.
  - kind=TRAP: o_redirect_pc = {i_mtvec[W-1:2], 2'b00}, sampled live so the committed CSR state is visible.
  - kind=MRET: o_redirect_pc = i_mepc.
  - All *_ff codes = NO_EXC.
  - Hold until i_redirect_ready=1 on an enabled edge, then go to IDLE.
- Latency: request sampled at edge N; COMMIT during N+1; earliest redirect handshake at edge N+2; IDLE from N+3.
- All new requests are ignored outside IDLE.
- i_clk_en=0: state, latches and outputs hold. A ready seen while disabled is not a handshake.
- Reset mid-sequence returns to IDLE on the next edge. No CSR strobe is emitted; o_redirect_valid drops.
- W-bit PCs pass through unmodified; no arithmetic beyond masking mtvec[1:0].

Optional Feature:
- Macro TRAP_COUNTER_EN.
- When defined:
  - Adds output o_trap_count [63:0], which increments by 1 on every COMMIT of kind=TRAP (not MRET) and saturates at all-ones.
  - Reset value 0.
  - Frozen when i_clk_en=0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - NO_EXC.
  - State encodings IDLE=2'd0, COMMIT=2'd1, REDIRECT=2'd2.
  - Kind encodings TRAP/MRET.
  - Cause constants: instr-misaligned 0, illegal 2, load-misaligned 4, store-misaligned 6, ecall-M 11.
- One natural sub-module: trap_arbiter. It is combinational priority select of M/mret/F requests, producing a winner one-hot plus a selected code/pc/addr bundle.
- The FSM and latches stay in the top.

Test Plan:
- Reset: assert i_rst 2 cycles with requests active -> all outputs at reset values, state IDLE, no *_ff code other than 4'hF.
- M exception:
  - Stimulus: code 4, pc 0x1000, addr 0x2003, mtvec 0x8001; ready held 1.
  - Next cycle: o_exception_code_e_m_ff=4, pc 0x1000, addr 0x2003, o_flush=1.
  - Following cycle: o_redirect_valid=1, o_redirect_pc=0x8000; then IDLE.
- Simultaneous events: M code 6 and mret and F code 0 in one cycle -> only the E/M slot commits code 6; o_mret_e stays 0; F code stays 4'hF.
- mret vs F: mret and F exception together, mepc 0x4444 -> o_mret_e pulse 1 cycle, F code stays 4'hF, redirect to 0x4444.
- Backpressure/enable:
  - Hold ready=0 for 5 cycles in REDIRECT -> valid, pc and flush stable, new requests ignored.
  - Drop i_clk_en with ready=1 -> no transition; raise i_clk_en -> handshake, then IDLE.
- TRAP_COUNTER_EN: 3 traps + 1 mret -> o_trap_count=3. Reset mid-REDIRECT -> count 0, valid 0 next cycle.
